// File: rtl/vec_mem_sequencer.sv
// Moves 256-bit vectors between the vector register file (v16-v23) and 32-bit data memory,
// one memory beat per lane, with a single register-file read (store) or write pulse (load).
module vec_mem_sequencer #(
   parameter int LANES  = 8,
   parameter int LANE_W = 32,
   parameter int STRIDE = 4,
   parameter int VBASE  = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic                    is_store_i,
   input  logic [4:0]              vreg_i,
   input  logic [31:0]             base_addr_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o,
   output logic [4:0]              vra_o,
   input  logic [LANES*LANE_W-1:0] vrd_i,
   output logic                    vwe_o,
   output logic [4:0]              vwa_o,
   output logic [LANES*LANE_W-1:0] vwd_o,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [31:0]             mem_addr_o,
   output logic [LANE_W-1:0]       mem_wd_o,
   input  logic                    mem_ack_i,
   input  logic [LANE_W-1:0]       mem_rd_i
);

   localparam int BEAT_W = $clog2(LANES);
   localparam int VEC_W  = LANES * LANE_W;

   typedef enum logic [2:0] {IDLE, READ, XFER, WB, DONE} state_e;

   state_e            state_q;
   logic              isStore_q;
   logic [4:0]        vreg_q;
   logic [31:0]       base_q;
   logic [BEAT_W-1:0] beat_q;
   logic [BEAT_W-1:0] beat_d;
   logic [VEC_W-1:0]  buffer_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic              vwe_q;
   logic              memReq_q;
   logic              memWe_q;
   logic              reqLegal;
   logic              lastBeat;

   assign beat_d   = beat_q + BEAT_W'(1);
   assign lastBeat = (beat_q == BEAT_W'(LANES - 1));
   assign reqLegal = (vreg_i >= 5'(VBASE)) && (vreg_i <= 5'(VBASE + LANES - 1))
                     && (base_addr_i[1:0] == 2'b00);

   // Address and store data follow the latched base, beat counter and buffer, so they
   // stay frozen for as long as the memory withholds its acknowledge.
   assign mem_addr_o = base_q + 32'(STRIDE) * 32'(beat_q);
   assign mem_wd_o   = buffer_q[LANE_W*beat_q +: LANE_W];
   assign vra_o      = vreg_q;
   assign vwa_o      = vreg_q;
   assign vwd_o      = buffer_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign vwe_o      = vwe_q;
   assign mem_req_o  = memReq_q;
   assign mem_we_o   = memWe_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         isStore_q <= 1'b0;
         vreg_q    <= '0;
         base_q    <= '0;
         beat_q    <= '0;
         buffer_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         vwe_q     <= 1'b0;
         memReq_q  <= 1'b0;
         memWe_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         vwe_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  isStore_q <= is_store_i;
                  vreg_q    <= vreg_i;
                  base_q    <= base_addr_i;
                  beat_q    <= '0;
                  if (!reqLegal) begin
                     err_q <= 1'b1;
                  end else if (is_store_i) begin
                     state_q <= READ;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q  <= XFER;
                     busy_q   <= 1'b1;
                     memReq_q <= 1'b1;
                     memWe_q  <= 1'b0;
                  end
               end
            end
            READ: begin
               buffer_q <= vrd_i;
               state_q  <= XFER;
               memReq_q <= 1'b1;
               memWe_q  <= 1'b1;
            end
            XFER: begin
               if (mem_ack_i) begin
                  if (!isStore_q) begin
                     buffer_q[LANE_W*beat_q +: LANE_W] <= mem_rd_i;
                  end
                  beat_q <= beat_d;
                  if (lastBeat) begin
                     memReq_q <= 1'b0;
                     memWe_q  <= 1'b0;
                     if (isStore_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= WB;
                        vwe_q   <= 1'b1;
                     end
                  end
               end
            end
            WB: begin
               state_q <= DONE;
               done_q  <= 1'b1;
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q  <= IDLE;
               busy_q   <= 1'b0;
               memReq_q <= 1'b0;
               memWe_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer: word-addressed memory and register-file models,
// cycle-by-cycle observation, and immediate-assertion checks against hand-computed values.
module tb_vec_mem_sequencer;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         start_i;
   logic         is_store_i;
   logic [4:0]   vreg_i;
   logic [31:0]  base_addr_i;
   logic         busy_o;
   logic         done_o;
   logic         err_o;
   logic [4:0]   vra_o;
   logic [255:0] vrd_i;
   logic         vwe_o;
   logic [4:0]   vwa_o;
   logic [255:0] vwd_o;
   logic         mem_req_o;
   logic         mem_we_o;
   logic [31:0]  mem_addr_o;
   logic [31:0]  mem_wd_o;
   logic         mem_ack_i;
   logic [31:0]  mem_rd_i;

   logic [31:0]  memArr [0:255];
   logic [255:0] rf [0:31];

   int           vecCount = 0;
   int           missCount = 0;

   int           vweCnt, vweCyc, doneCnt, doneCyc, errCnt, errCyc, wrCnt, rdCnt;
   int           stallFrom, stallLen;
   logic         busySeen, reqSeen, stallBad, churn;
   logic [4:0]   vwaSeen;
   logic [255:0] vwdSeen;
   logic [31:0]  stallAddr;
   logic [31:0]  wrAddr [0:7];
   logic [31:0]  wrData [0:7];
   logic         busyLog [0:31];
   logic [4:0]   vraLog [0:31];
   logic [31:0]  storeLane [0:7];

   vec_mem_sequencer dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .start_i     (start_i),
      .is_store_i  (is_store_i),
      .vreg_i      (vreg_i),
      .base_addr_i (base_addr_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .vra_o       (vra_o),
      .vrd_i       (vrd_i),
      .vwe_o       (vwe_o),
      .vwa_o       (vwa_o),
      .vwd_o       (vwd_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wd_o    (mem_wd_o),
      .mem_ack_i   (mem_ack_i),
      .mem_rd_i    (mem_rd_i)
   );

   always #5 clk_i = ~clk_i;

   assign vrd_i    = rf[vra_o];
   assign mem_rd_i = memArr[mem_addr_o[9:2]];

   // Register-file and memory writes land mid-cycle, as the real falling-edge storage does.
   always @(negedge clk_i) begin
      if (vwe_o) rf[vwa_o] = vwd_o;
      if (mem_req_o && mem_ack_i && mem_we_o) memArr[mem_addr_o[9:2]] = mem_wd_o;
   end

   task automatic checkOutput(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
      vecCount++;
      assert (observed === expected) else begin
         missCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic clearWatch();
      vweCnt = 0; vweCyc = 0; doneCnt = 0; doneCyc = 0; errCnt = 0; errCyc = 0;
      wrCnt = 0; rdCnt = 0; busySeen = 0; reqSeen = 0; stallBad = 0;
      vwaSeen = '0; vwdSeen = '0; stallAddr = '0;
      stallFrom = 0; stallLen = 0;
      for (int i = 0; i < 32; i++) begin
         busyLog[i] = 1'b0;
         vraLog[i]  = '0;
      end
   endtask

   task automatic applyStimulus(input logic st, input logic [4:0] vr, input logic [31:0] base,
                                input logic hold);
      clearWatch();
      start_i = 1'b1; is_store_i = st; vreg_i = vr; base_addr_i = base;
      @(posedge clk_i); #1;
      if (!hold) start_i = 1'b0;
   endtask

   // Observes cycles 1..n after the sampling edge; time is #1 past each rising edge.
   task automatic watchCycles(input int n);
      for (int c = 1; c <= n; c++) begin
         mem_ack_i = !(c >= stallFrom && c < stallFrom + stallLen);
         if (churn) vreg_i = 5'd16 + 5'(c % 8);
         if (c < 32) begin
            busyLog[c] = busy_o;
            vraLog[c]  = vra_o;
         end
         if (vwe_o) begin vweCnt++; vweCyc = c; vwaSeen = vwa_o; vwdSeen = vwd_o; end
         if (done_o) begin doneCnt++; doneCyc = c; end
         if (err_o) begin errCnt++; errCyc = c; end
         if (busy_o) busySeen = 1'b1;
         if (mem_req_o) reqSeen = 1'b1;
         if (c >= stallFrom && c < stallFrom + stallLen) begin
            if (!mem_req_o) stallBad = 1'b1;
            if (c == stallFrom) stallAddr = mem_addr_o;
            else if (mem_addr_o !== stallAddr) stallBad = 1'b1;
         end
         if (mem_req_o && mem_ack_i) begin
            if (mem_we_o) begin
               if (wrCnt < 8) begin wrAddr[wrCnt] = mem_addr_o; wrData[wrCnt] = mem_wd_o; end
               wrCnt++;
            end else begin
               rdCnt++;
            end
         end
         @(posedge clk_i); #1;
      end
      mem_ack_i = 1'b1;
   endtask

   initial begin
      rst_ni = 1'b0; start_i = 1'b0; is_store_i = 1'b0; vreg_i = '0; base_addr_i = '0;
      mem_ack_i = 1'b1; churn = 1'b0;
      clearWatch();
      for (int i = 0; i < 256; i++) memArr[i] = '0;
      for (int i = 0; i < 32; i++) rf[i] = '0;
      for (int i = 0; i < 8; i++) memArr[8'h40 + i] = 32'h11111111 * (i + 1);
      for (int i = 0; i < 8; i++) memArr[8'hC0 + i] = 32'hA0000000 + i;
      rf[20] = 256'h01234567_89ABCDEF_02468ACE_13579BDF_FEDCBA98_76543210_0F1E2D3C_4B5A6978;
      storeLane[0] = 32'h4B5A6978; storeLane[1] = 32'h0F1E2D3C;
      storeLane[2] = 32'h76543210; storeLane[3] = 32'hFEDCBA98;
      storeLane[4] = 32'h13579BDF; storeLane[5] = 32'h02468ACE;
      storeLane[6] = 32'h89ABCDEF; storeLane[7] = 32'h01234567;

      #3;
      checkOutput("rst_busy", busy_o, 0);
      checkOutput("rst_pulses", {done_o, err_o, vwe_o}, 0);
      checkOutput("rst_mem", {mem_req_o, mem_we_o, mem_addr_o, mem_wd_o}, 0);
      checkOutput("rst_rf", {vra_o, vwa_o}, 0);
      checkOutput("rst_vwd", vwd_o, 0);
      #9 rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // Basic load of v17 from 0x100.
      applyStimulus(1'b0, 5'd17, 32'h100, 1'b0);
      checkOutput("load_c1_addr", mem_addr_o, 32'h100);
      checkOutput("load_c1_req", {busy_o, mem_req_o, mem_we_o}, 3'b110);
      watchCycles(11);
      checkOutput("load_vwe_cnt", vweCnt, 1);
      checkOutput("load_vwe_cyc", vweCyc, 9);
      checkOutput("load_vwa", vwaSeen, 17);
      checkOutput("load_vwd", vwdSeen,
         256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);
      checkOutput("load_done_cyc", doneCyc, 10);
      checkOutput("load_beats", {rdCnt, wrCnt}, {32'd8, 32'd0});
      checkOutput("load_idle_after", busy_o, 0);

      // Store of v20 to 0x200.
      applyStimulus(1'b1, 5'd20, 32'h200, 1'b0);
      checkOutput("store_c1_read", {busy_o, mem_req_o, vra_o}, {2'b10, 5'd20});
      watchCycles(11);
      checkOutput("store_wr_cnt", wrCnt, 8);
      checkOutput("store_rd_cnt", rdCnt, 0);
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("store_addr%0d", k), wrAddr[k], 32'h200 + 32'(4 * k));
         checkOutput($sformatf("store_data%0d", k), wrData[k], storeLane[k]);
      end
      checkOutput("store_done_cyc", doneCyc, 10);
      checkOutput("store_no_vwe", vweCnt, 0);
      checkOutput("store_mem_lane7", memArr[8'h87], 32'h01234567);

      // Load with three wait cycles on beat 4.
      applyStimulus(1'b0, 5'd21, 32'h100, 1'b0);
      stallFrom = 5; stallLen = 3;
      watchCycles(14);
      checkOutput("bp_stall_addr", stallAddr, 32'h110);
      checkOutput("bp_stable", stallBad, 0);
      checkOutput("bp_vwe_cyc", vweCyc, 12);
      checkOutput("bp_done_cyc", doneCyc, 13);
      checkOutput("bp_vwd", vwdSeen,
         256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);

      // Illegal requests.
      applyStimulus(1'b0, 5'd5, 32'h100, 1'b0);
      watchCycles(3);
      checkOutput("rej5_err", {errCnt, errCyc}, {32'd1, 32'd1});
      checkOutput("rej5_quiet", {busySeen, reqSeen, vweCnt != 0}, 0);
      applyStimulus(1'b1, 5'd24, 32'h100, 1'b0);
      watchCycles(3);
      checkOutput("rej24_err", {errCnt, errCyc}, {32'd1, 32'd1});
      checkOutput("rej24_quiet", {busySeen, reqSeen, vweCnt != 0}, 0);
      applyStimulus(1'b0, 5'd17, 32'h102, 1'b0);
      watchCycles(3);
      checkOutput("rejal_err", {errCnt, errCyc}, {32'd1, 32'd1});
      checkOutput("rejal_quiet", {busySeen, reqSeen, vweCnt != 0}, 0);

      // Reset in the middle of a load, after beat 5 is acknowledged.
      applyStimulus(1'b0, 5'd18, 32'h100, 1'b0);
      watchCycles(6);
      rst_ni = 1'b0;
      #1;
      checkOutput("abort_ctl", {busy_o, done_o, err_o, vwe_o, mem_req_o, mem_we_o}, 0);
      checkOutput("abort_addr", {mem_addr_o, mem_wd_o, vra_o, vwa_o}, 0);
      checkOutput("abort_vwd", vwd_o, 0);
      #2 rst_ni = 1'b1;
      @(posedge clk_i); #1;
      clearWatch();
      watchCycles(3);
      checkOutput("abort_no_vwe", vweCnt, 0);
      checkOutput("abort_rf18", rf[18], 0);
      applyStimulus(1'b0, 5'd19, 32'h300, 1'b0);
      watchCycles(11);
      checkOutput("reload_vwa", vwaSeen, 19);
      checkOutput("reload_vwd", vwdSeen,
         256'hA0000007_A0000006_A0000005_A0000004_A0000003_A0000002_A0000001_A0000000);
      checkOutput("reload_rf19", rf[19],
         256'hA0000007_A0000006_A0000005_A0000004_A0000003_A0000002_A0000001_A0000000);

      // start held high with a changing vreg: first request only, relaunch from IDLE.
      applyStimulus(1'b0, 5'd22, 32'h100, 1'b1);
      churn = 1'b1;
      watchCycles(12);
      churn = 1'b0;
      start_i = 1'b0;
      checkOutput("hold_vwe_cnt", vweCnt, 1);
      checkOutput("hold_vwa", vwaSeen, 22);
      checkOutput("hold_vra_c5", vraLog[5], 22);
      checkOutput("hold_done_cyc", doneCyc, 10);
      checkOutput("hold_idle_c11", busyLog[11], 0);
      checkOutput("hold_relaunch", {busyLog[12], vraLog[12]}, {1'b1, 5'd19});
      clearWatch();
      watchCycles(12);
      checkOutput("hold_second", {vweCnt, doneCnt}, {32'd1, 32'd1});
      checkOutput("hold_second_vwa", vwaSeen, 19);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
